// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and imem.
// One request in flight at a time: req/gnt handshake, then a single rvalid beat.
interface if_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: issues one imem fetch at a time at pc, holds the PC via stall_if
// until IF/ID takes the instruction, buffers it under ID stalls, and drops stale responses.
module if_fetch_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc,
    input  logic                  redirect,
    input  logic                  id_stall,
    if_fetch_ctrl_if.master       imem,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic                  stall_if,
    output logic                  err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] buffer_reg, buffer_next;
    logic [7:0]  timer_reg, timer_next;
    logic        err_reg, err_next;

    logic        req_c;
    logic        valid_c;
    logic [31:0] instr_c;
    logic        count_en;
    logic        timer_clr;
    logic        advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            buffer_reg <= NOP_INSTR;
            timer_reg  <= 8'd0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buffer_reg <= buffer_next;
            timer_reg  <= timer_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        buffer_next = buffer_reg;
        req_c       = 1'b0;
        valid_c     = 1'b0;
        instr_c     = NOP_INSTR;
        count_en    = 1'b0;
        timer_clr   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                state_next = S_REQ;
            end

            S_REQ: begin
                req_c = 1'b1;
                if (imem.gnt) begin
                    timer_clr = 1'b1;
                    // A redirect in the grant cycle orphans the response already in flight.
                    state_next = redirect ? S_FLUSH : S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem.rvalid) begin
                    if (redirect) begin
                        state_next = S_REQ;
                    end else begin
                        valid_c = 1'b1;
                        instr_c = imem.rdata;
                        if (id_stall) begin
                            buffer_next = imem.rdata;
                            state_next  = S_HOLD;
                        end else begin
                            state_next = S_REQ;
                        end
                    end
                end else begin
                    count_en = 1'b1;
                    if (redirect) begin
                        state_next = S_FLUSH;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    state_next = S_REQ;
                end else begin
                    valid_c = 1'b1;
                    instr_c = buffer_reg;
                    if (!id_stall) begin
                        state_next = S_REQ;
                    end
                end
            end

            S_FLUSH: begin
                // Further redirects here change nothing: the single stale beat still has to drain.
                if (imem.rvalid) begin
                    state_next = S_REQ;
                end else begin
                    count_en = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Timer saturates at TIMEOUT; err latches on the cycle the limit is reached.
    always_comb begin
        timer_next = timer_reg;
        err_next   = err_reg;
        if (timer_clr) begin
            timer_next = 8'd0;
        end else if (count_en && (timer_reg != TIMEOUT_CNT)) begin
            timer_next = timer_reg + 8'd1;
            if ((timer_reg + 8'd1) == TIMEOUT_CNT) begin
                err_next = 1'b1;
            end
        end
    end

    assign advance = valid_c && !id_stall;

    always_comb begin
        imem.req    = 1'b0;
        instr_valid = 1'b0;
        instr       = NOP_INSTR;
        stall_if    = 1'b1;
        if (!rst) begin
            imem.req    = req_c;
            instr_valid = valid_c;
            instr       = valid_c ? instr_c : NOP_INSTR;
            if (state_reg != S_IDLE) begin
                stall_if = !(redirect || advance);
            end
        end
    end

    assign imem.addr = pc;
    assign err       = err_reg;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a randomized run against a
// transaction-level model (outstanding/stale/held flags) and a variable-latency imem.
module tb_if_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        redirect;
    logic        id_stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall_if;
    logic        err;

    if_fetch_ctrl_if bus();

    if_fetch_ctrl #(.NOP_INSTR(NOP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .id_stall(id_stall),
        .imem(bus), .instr(instr), .instr_valid(instr_valid), .stall_if(stall_if), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] new_pc = 32'h0;

    // Reference model: what the fetcher is waiting on, not how it encodes it.
    bit          m_started, m_out, m_stale, m_held, m_err;
    logic [31:0] m_held_data = 32'h0;
    int          m_quiet;
    bit          exp_req, exp_valid, exp_stall;
    logic [31:0] exp_instr;

    // Memory slave model.
    bit          s_busy, s_mute, s_gnt_rand, s_spurious, s_rand_data;
    int          s_left, s_lat_min = 1, s_lat_max = 1;
    logic [31:0] s_data = 32'h0, s_next_data = 32'h0;

    task automatic model_eval();
        exp_req   = 1'b0;
        exp_valid = 1'b0;
        exp_instr = NOP;
        if (!rst && m_started) begin
            if (m_held) begin
                exp_valid = !redirect;
                if (exp_valid) exp_instr = m_held_data;
            end else if (m_out) begin
                if (!m_stale && bus.rvalid && !redirect) begin
                    exp_valid = 1'b1;
                    exp_instr = bus.rdata;
                end
            end else begin
                exp_req = 1'b1;
            end
        end
        exp_stall = (rst || !m_started) ? 1'b1 : !(redirect || (exp_valid && !id_stall));
    endtask

    task automatic cycle_begin();
        bus.gnt    = s_gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rvalid = s_spurious || (s_busy && s_left == 0 && !s_mute);
        bus.rdata  = (s_busy && s_left == 0) ? s_data : $urandom;
        #2;
        model_eval();
    endtask

    task automatic cycle_end();
        bit granted, mgrant, rv;
        logic [31:0] rd;
        granted = bus.req && bus.gnt && !rst;
        mgrant  = exp_req && bus.gnt;
        rv      = bus.rvalid;
        rd      = bus.rdata;
        @(posedge clk);
        #1;
        if (rst) begin
            m_started = 0; m_out = 0; m_stale = 0; m_held = 0; m_quiet = 0; m_err = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_held) begin
            if (redirect || !id_stall) m_held = 0;
        end else if (m_out) begin
            if (rv) begin
                if (!m_stale && !redirect && id_stall) begin
                    m_held = 1;
                    m_held_data = rd;
                end
                m_out = 0;
                m_stale = 0;
            end else begin
                if (redirect) m_stale = 1;
                if (m_quiet < TMO) m_quiet++;
                if (m_quiet == TMO) m_err = 1;
            end
        end else if (mgrant) begin
            m_out = 1;
            m_stale = redirect;
            m_quiet = 0;
        end
        if (!exp_stall) pc = redirect ? new_pc : pc + 32'd4;
        if (rst) begin
            s_busy = 0;
        end else begin
            if (s_busy && s_left == 0 && !s_mute) s_busy = 0;
            else if (s_busy && s_left > 0) s_left--;
            if (granted) begin
                s_busy = 1;
                s_left = int'($urandom_range(s_lat_min, s_lat_max)) - 1;
                s_data = s_rand_data ? $urandom : s_next_data;
            end
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1; redirect = 0; id_stall = 0;
        s_spurious = 0; s_mute = 0; s_gnt_rand = 0; s_rand_data = 0;
        pc = start_pc;
        repeat (2) begin cycle_begin(); cycle_end(); end
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; redirect = 0; id_stall = 0; pc = 32'h1000;
        s_spurious = 1; s_mute = 0; s_gnt_rand = 0; s_rand_data = 0;
        s_lat_min = 2; s_lat_max = 2; s_next_data = 32'h00A00113;
        for (int i = 0; i < 2; i++) begin
            cycle_begin();
            vectors++; if (bus.req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %0b want 0", bus.req); end
            vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
            vectors++; if (instr !== NOP) begin miscompares++; $display("FAIL rst_instr got %h want %h", instr, NOP); end
            vectors++; if (stall_if !== 1'b1) begin miscompares++; $display("FAIL rst_stall got %0b want 1", stall_if); end
            cycle_end();
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %0b want 0", err); end
        end
        rst = 0;
        cycle_begin();
        vectors++; if (bus.req !== 1'b0 || instr_valid !== 1'b0 || stall_if !== 1'b1) begin
            miscompares++; $display("FAIL idle_out got req=%0b valid=%0b stall=%0b want 0 0 1", bus.req, instr_valid, stall_if); end
        cycle_end();
        cycle_begin();
        vectors++; if (bus.req !== 1'b1 || instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL req_spurious got req=%0b valid=%0b want 1 0", bus.req, instr_valid); end
        cycle_end();
        s_spurious = 0;
        cycle_begin();
        vectors++; if (instr_valid !== 1'b0 || stall_if !== 1'b1) begin
            miscompares++; $display("FAIL wait_first got valid=%0b stall=%0b want 0 1", instr_valid, stall_if); end
        cycle_end();
        cycle_begin();
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h00A00113) begin
            miscompares++; $display("FAIL wait_data got valid=%0b instr=%h want 1 00a00113", instr_valid, instr); end
        cycle_end();
        $display("reset: spurious rvalid ignored, fetch at 0x1000 delivered");
    endtask

    task automatic test_zero_wait();
        s_lat_min = 1; s_lat_max = 1; s_next_data = 32'h00100093;
        do_reset(32'h0);
        cycle_begin();
        vectors++; if (bus.req !== 1'b0 || stall_if !== 1'b1) begin
            miscompares++; $display("FAIL zw_idle got req=%0b stall=%0b want 0 1", bus.req, stall_if); end
        cycle_end();
        cycle_begin();
        vectors++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin
            miscompares++; $display("FAIL zw_req got req=%0b addr=%h want 1 00000000", bus.req, bus.addr); end
        cycle_end();
        cycle_begin();
        vectors++; if (instr_valid !== 1'b1 || stall_if !== 1'b0 || instr !== 32'h00100093) begin
            miscompares++; $display("FAIL zw_data got valid=%0b stall=%0b instr=%h want 1 0 00100093", instr_valid, stall_if, instr); end
        cycle_end();
        cycle_begin();
        vectors++; if (bus.req !== 1'b1 || bus.addr !== 32'h4) begin
            miscompares++; $display("FAIL zw_next got req=%0b addr=%h want 1 00000004", bus.req, bus.addr); end
        cycle_end();
        $display("zero_wait: fetch 0x0 -> 00100093, next request 0x4");
    endtask

    task automatic test_latency();
        s_lat_min = 4; s_lat_max = 4; s_next_data = 32'h00500093;
        do_reset(32'h20);
        cycle_begin(); cycle_end();
        cycle_begin(); cycle_end();
        for (int i = 0; i < 3; i++) begin
            cycle_begin();
            vectors++; if (stall_if !== 1'b1 || instr_valid !== 1'b0 || bus.req !== 1'b0) begin
                miscompares++; $display("FAIL lat_wait%0d got stall=%0b valid=%0b req=%0b want 1 0 0", i, stall_if, instr_valid, bus.req); end
            cycle_end();
        end
        cycle_begin();
        vectors++; if (instr !== 32'h00500093 || instr_valid !== 1'b1 || stall_if !== 1'b0) begin
            miscompares++; $display("FAIL lat_data got instr=%h valid=%0b stall=%0b want 00500093 1 0", instr, instr_valid, stall_if); end
        cycle_end();
        $display("latency: 3 wait cycles then 00500093 at 0x20");
    endtask

    task automatic test_hold();
        s_lat_min = 1; s_lat_max = 1; s_next_data = 32'h00500093;
        do_reset(32'h40);
        cycle_begin(); cycle_end();
        cycle_begin(); cycle_end();
        id_stall = 1;
        cycle_begin();
        vectors++; if (instr_valid !== 1'b1 || stall_if !== 1'b1 || instr !== 32'h00500093) begin
            miscompares++; $display("FAIL hold_arrive got valid=%0b stall=%0b instr=%h want 1 1 00500093", instr_valid, stall_if, instr); end
        cycle_end();
        for (int i = 0; i < 2; i++) begin
            cycle_begin();
            vectors++; if (instr !== 32'h00500093 || instr_valid !== 1'b1 || stall_if !== 1'b1 || bus.req !== 1'b0) begin
                miscompares++; $display("FAIL hold_cyc%0d got instr=%h valid=%0b stall=%0b req=%0b want 00500093 1 1 0", i, instr, instr_valid, stall_if, bus.req); end
            cycle_end();
        end
        id_stall = 0;
        cycle_begin();
        vectors++; if (stall_if !== 1'b0 || instr !== 32'h00500093) begin
            miscompares++; $display("FAIL hold_release got stall=%0b instr=%h want 0 00500093", stall_if, instr); end
        cycle_end();
        cycle_begin();
        vectors++; if (bus.req !== 1'b1 || bus.addr !== 32'h44) begin
            miscompares++; $display("FAIL hold_next got req=%0b addr=%h want 1 00000044", bus.req, bus.addr); end
        cycle_end();
        $display("hold: 00500093 buffered through id_stall, next request 0x44");
    endtask

    task automatic test_redirect_wait();
        s_lat_min = 3; s_lat_max = 3; s_next_data = 32'hDEADBEEF;
        do_reset(32'h60);
        cycle_begin(); cycle_end();
        cycle_begin(); cycle_end();
        redirect = 1; new_pc = 32'h100;
        cycle_begin();
        vectors++; if (stall_if !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL rw_redirect got stall=%0b valid=%0b want 0 0", stall_if, instr_valid); end
        cycle_end();
        redirect = 0;
        cycle_begin();
        vectors++; if (stall_if !== 1'b1 || instr_valid !== 1'b0 || bus.req !== 1'b0) begin
            miscompares++; $display("FAIL rw_flush got stall=%0b valid=%0b req=%0b want 1 0 0", stall_if, instr_valid, bus.req); end
        cycle_end();
        cycle_begin();
        vectors++; if (instr_valid !== 1'b0 || instr !== NOP || bus.rvalid !== 1'b1) begin
            miscompares++; $display("FAIL rw_drop got valid=%0b instr=%h rvalid=%0b want 0 %h 1", instr_valid, instr, bus.rvalid, NOP); end
        cycle_end();
        cycle_begin();
        vectors++; if (bus.req !== 1'b1 || bus.addr !== 32'h100) begin
            miscompares++; $display("FAIL rw_newpc got req=%0b addr=%h want 1 00000100", bus.req, bus.addr); end
        cycle_end();
        $display("redirect_wait: stale beat dropped, refetch at 0x100");
    endtask

    task automatic test_redirect_gnt();
        s_lat_min = 3; s_lat_max = 3; s_next_data = 32'hBADC0DE0;
        do_reset(32'h80);
        cycle_begin(); cycle_end();
        redirect = 1; new_pc = 32'h200;
        cycle_begin();
        vectors++; if (stall_if !== 1'b0 || bus.req !== 1'b1) begin
            miscompares++; $display("FAIL rg_gnt got stall=%0b req=%0b want 0 1", stall_if, bus.req); end
        cycle_end();
        new_pc = 32'h300;
        cycle_begin();
        vectors++; if (stall_if !== 1'b0 || instr_valid !== 1'b0 || bus.req !== 1'b0) begin
            miscompares++; $display("FAIL rg_flush_redirect got stall=%0b valid=%0b req=%0b want 0 0 0", stall_if, instr_valid, bus.req); end
        cycle_end();
        redirect = 0;
        cycle_begin(); cycle_end();
        cycle_begin();
        vectors++; if (instr_valid !== 1'b0 || bus.rvalid !== 1'b1) begin
            miscompares++; $display("FAIL rg_drop got valid=%0b rvalid=%0b want 0 1", instr_valid, bus.rvalid); end
        cycle_end();
        s_lat_min = 1; s_lat_max = 1; s_next_data = 32'h00300193;
        cycle_begin();
        vectors++; if (bus.req !== 1'b1 || bus.addr !== 32'h300) begin
            miscompares++; $display("FAIL rg_newpc got req=%0b addr=%h want 1 00000300", bus.req, bus.addr); end
        cycle_end();
        cycle_begin();
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h00300193) begin
            miscompares++; $display("FAIL rg_data got valid=%0b instr=%h want 1 00300193", instr_valid, instr); end
        cycle_end();
        $display("redirect_gnt: one stale beat dropped, fetch at 0x300 delivered");
    endtask

    task automatic test_timeout();
        s_lat_min = 1; s_lat_max = 1;
        do_reset(32'hC0);
        s_mute = 1;
        cycle_begin(); cycle_end();
        cycle_begin(); cycle_end();
        for (int i = 0; i < TMO; i++) begin
            cycle_begin();
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL tmo_early%0d got err=%0b want 0", i, err); end
            cycle_end();
        end
        for (int i = 0; i < 5; i++) begin
            cycle_begin();
            vectors++; if (err !== 1'b1 || bus.req !== 1'b0 || instr_valid !== 1'b0) begin
                miscompares++; $display("FAIL tmo_sticky%0d got err=%0b req=%0b valid=%0b want 1 0 0", i, err, bus.req, instr_valid); end
            cycle_end();
        end
        rst = 1;
        cycle_begin(); cycle_end();
        rst = 0; s_mute = 0;
        cycle_begin();
        vectors++; if (err !== 1'b0 || bus.req !== 1'b0 || stall_if !== 1'b1) begin
            miscompares++; $display("FAIL tmo_clear got err=%0b req=%0b stall=%0b want 0 0 1", err, bus.req, stall_if); end
        cycle_end();
        $display("timeout: err after %0d silent wait cycles, cleared by rst", TMO);
    endtask

    task automatic test_random();
        s_lat_min = 1; s_lat_max = 3;
        do_reset(32'h400);
        s_gnt_rand = 1; s_rand_data = 1;
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            redirect = ($urandom_range(0, 4) == 0);
            id_stall = ($urandom_range(0, 2) == 0);
            new_pc   = {$urandom_range(0, 32'hFFFF), 2'b00};
            cycle_begin();
            vectors++; if (bus.req !== exp_req) begin miscompares++; $display("FAIL rnd_req cyc%0d got %0b want %0b", n, bus.req, exp_req); end
            vectors++; if (instr_valid !== exp_valid) begin miscompares++; $display("FAIL rnd_valid cyc%0d got %0b want %0b", n, instr_valid, exp_valid); end
            vectors++; if (instr !== exp_instr) begin miscompares++; $display("FAIL rnd_instr cyc%0d got %h want %h", n, instr, exp_instr); end
            vectors++; if (stall_if !== exp_stall) begin miscompares++; $display("FAIL rnd_stall cyc%0d got %0b want %0b", n, stall_if, exp_stall); end
            vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rnd_err cyc%0d got %0b want %0b", n, err, m_err); end
            if (exp_req) begin
                vectors++; if (bus.addr !== pc) begin miscompares++; $display("FAIL rnd_addr cyc%0d got %h want %h", n, bus.addr, pc); end
            end
            if (exp_valid && !id_stall) $display("consume cyc%0d pc=%h instr=%h", n, pc, exp_instr);
            cycle_end();
        end
        rst = 0; redirect = 0; id_stall = 0;
    endtask

    initial begin
        rst = 1; redirect = 0; id_stall = 0; pc = 32'h0;
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 32'h0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_hold();
        test_redirect_wait();
        test_redirect_gnt();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch sequencer between the PC/IF stage and a handshaked, variable-latency instruction memory. It issues one fetch at a time at the current PC and drives stall_if to hold the PC until an instruction is handed to IF/ID. It buffers the instruction while ID is stalled and discards stale responses after a branch redirect.

Parameters:
NOP_INSTR, 32'h00000013, value driven on instr when instr_valid=0 (addi x0,x0,0)
TIMEOUT, 255, max cycles waiting for imem_rvalid before err is raised (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
pc  input  32  current PC from the PC register
redirect  input  1  pc_src from EX; PC loads new_pc this cycle
id_stall  input  1  ID stage cannot accept an instruction this cycle
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (equals pc)
imem_gnt  input  1  memory accepted request this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
instr  output  32  instruction to IF/ID
instr_valid  output  1  instr is a real fetched instruction
stall_if  output  1  hold PC (to PC.stall_if)
err  output  1  sticky fetch timeout flag

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates occur on the rising edge of clk.
- States: IDLE, REQ, WAIT, HOLD, FLUSH. Reset -> IDLE, buffer=NOP_INSTR, timer=0, err=0.
- Outputs while rst=1 or in IDLE: imem_req=0, instr_valid=0, instr=NOP_INSTR, stall_if=1.
- IDLE: next state is REQ unconditionally (one-cycle gap after reset).
- stall_if = !(redirect | advance). advance=1 only in the cycle a valid instruction is consumed (instr_valid=1 and id_stall=0). redirect always releases the PC so it loads new_pc.
- REQ: imem_req=1, imem_addr=pc.
  - gnt=0: stay in REQ.
  - gnt=1 and redirect=0: go to WAIT, timer=0.
  - gnt=1 and redirect=1: go to FLUSH (the response belongs to the old path).
  - redirect without gnt: stay in REQ; the next cycle requests the new pc.
- WAIT: imem_req=0.
  - rvalid=1, redirect=0, id_stall=0: instr=imem_rdata, instr_valid=1 (combinational pass-through), go to REQ.
  - rvalid=1, redirect=0, id_stall=1: instr_valid=1 shown, rdata latched to buffer, go to HOLD.
  - rvalid=1 and redirect=1: data dropped, instr_valid=0, go to REQ.
  - rvalid=0 and redirect=1: go to FLUSH.
  - rvalid=0 and redirect=0: timer++.
- HOLD: instr=buffer, instr_valid=1, no request issued.
  - id_stall=0: go to REQ (advance).
  - redirect=1: instr_valid=0, buffer dropped, go to REQ. Redirect has priority over advance.
- FLUSH: instr_valid=0, stall_if=1 unless redirect.
  - rvalid=1: response discarded, go to REQ.
  - redirect in FLUSH: stay in FLUSH; only one response is outstanding.
- Timeout: the timer counts consecutive cycles in WAIT or FLUSH without rvalid.
  - When timer reaches TIMEOUT, err is set and stays sticky until rst. The state is unchanged and the timer saturates.
- rvalid outside WAIT/FLUSH is ignored.
- rst asserted mid-fetch: return to IDLE; a late rvalid arriving in IDLE or REQ is ignored.
- At most one request is outstanding; imem_req is never asserted in WAIT, HOLD or FLUSH.
- The block does no pc arithmetic; pc+4 stays in the IF datapath.

Test Plan:
- Reset then zero-wait memory (gnt same cycle, rvalid next), pc=0x0: cycle1 IDLE with req=0. Then req=1 at addr 0x0; next cycle instr_valid=1, stall_if=0; the next request is at 0x4.
- 3-cycle rvalid latency with rdata=0x00500093: stall_if=1 for 3 cycles in WAIT. On the rvalid cycle instr=0x00500093, instr_valid=1, stall_if=0.
- id_stall=1 for 2 cycles when rvalid arrives: HOLD for 2 cycles with instr constant at 0x00500093 and stall_if=1. When id_stall drops, stall_if=0 and the next request is issued.
- redirect in WAIT before rvalid, new_pc=0x100: FLUSH, and the late rdata is not presented (instr_valid=0). The next request has imem_addr=0x100.
- redirect in the same cycle as gnt, then a redirect again in FLUSH: stall_if=0 on each redirect cycle. Exactly one response is discarded, then a request issues at the latest pc.
- rvalid never returns, TIMEOUT=4: err rises after 4 WAIT cycles and remains 1 until rst=1, which clears err and returns to IDLE.
